debounce_sync: RTL

//   Upstream conditioning stage for the level-sensitive storage elements in this design.

---
 rtl/debounce_sync_if.sv | 22 ++
 rtl/debounce_sync.sv | 119 +++++++++++
 2 files changed

// File: rtl/debounce_sync_if.sv
// Signal bundle between a raw-input source and the debouncer.
// The master drives the raw level and the slave returns the clean level plus edge pulses.
interface debounce_sync_if;
    logic Din;
    logic Dout;
    logic Rise;
    logic Fall;

    modport master (
        output Din,
        input  Dout,
        input  Rise,
        input  Fall
    );

    modport slave (
        input  Din,
        output Dout,
        output Rise,
        output Fall
    );
endinterface

// File: rtl/debounce_sync.sv
// Synchronises a bouncing asynchronous input into Clk and accepts a new level only after
// STABLE_CYCLES consecutive mismatching samples; emits registered one-cycle Rise/Fall pulses.
module debounce_sync #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 1000,
    parameter int unsigned CNT_W         = 16
) (
    input  logic            Clk,
    input  logic            Rst,
    debounce_sync_if.slave  bus
);

    typedef enum logic [1:0] {
        S_LOW,
        W_HIGH,
        S_HIGH,
        W_LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               ONE_SHOT = (STABLE_CYCLES == 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   dout_q, dout_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync_q  <= '0;
            state_q <= S_LOW;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.Din};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // A W_ state reverts to its stable state as soon as s matches Dout again, dropping the count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            S_LOW: begin
                cnt_d = '0;
                if (s) begin
                    if (ONE_SHOT) begin
                        state_d = S_HIGH;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = W_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            W_HIGH: begin
                if (!s) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HIGH: begin
                cnt_d = '0;
                if (!s) begin
                    if (ONE_SHOT) begin
                        state_d = S_LOW;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = W_LOW;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            W_LOW: begin
                if (s) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
        dout_d = (state_d == S_HIGH) || (state_d == W_LOW);
    end

    assign bus.Dout = dout_q;
    assign bus.Rise = rise_q;
    assign bus.Fall = fall_q;

endmodule
